id_hazard_scheduler: RTL and testbench
======================================

// Module: id_hazard_scheduler
// PURPOSE
//  Issue/hazard controller for the ID stage of the 5-stage MIPS pipeline. Decodes the IF/ID instruction
//  and tracks in-flight writers in EX and MEM. Produces the ID stall, the ID/EX valid bit and the EX
//  operand-forwarding selects, and sequences a multi-cycle mult/div unit (HI/LO interlock).
// PARAMETERS
//  SIZE        32  datapath / instruction width
//  MULDIV_LAT  4   cycles a mult/div occupies the HI/LO unit after issue (>=1)
//  CNT_W       16  width of the saturating stall-cycle counter
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       reset; asynchronous assert, active-low
//  if_id_valid  in   1       IF/ID register holds a real instruction
//  if_id_instr  in   SIZE    instruction word, IF/ID[SIZE-1:0]
//  flush        in   1       branch/jump redirect; kill the instruction in ID this cycle
//  stall_if     out  1       hold PC and IF/ID (combinational)
//  id_ex_valid  out  1       ID/EX register holds an issued instruction (registered)
//  fwd_a        out  2       rs select in EX: 00 regfile, 01 EX/MEM, 10 MEM/WB (registered)
//  fwd_b        out  2       rt select in EX, same encoding (registered)
//  muldiv_busy  out  1       HI/LO unit occupied (counter != 0)
//  stall_cnt    out  CNT_W   saturating count of cycles with stall_if=1
// BEHAVIOUR
//  Reset: id_ex_valid=0, fwd_a=fwd_b=00, ex_q/mem_q tracking entries invalid, muldiv counter=0,
//   stall_cnt=0. Reset mid-operation discards all tracking state immediately.
//  Decode (combinational): R-type (op 000000) dst=rd, uses rs,rt. Exceptions: mult 011000 and div 011010
//   have no dst and set muldiv. mfhi 010000 and mflo 010010 have dst=rd, use neither rs nor rt, set hilo_rd.
//   lw 100011: dst=rt, uses rs, load=1. sw 101011: uses rs,rt. addi 001000: dst=rt, uses rs.
//   beq 000100: uses rs,rt. j 000010: nothing. Unknown opcode: nothing. dst=0 counts as no write.
//  Tracking entry = {valid, dst[4:0], we, load}. Each edge: mem_q<=ex_q; ex_q<=issue ? decoded : bubble.
//  issue = if_id_valid & ~stall_if & ~flush.
//  Load-use hazard: ex_q.valid & ex_q.load & ex_q.we & (ex_q.dst == a used rs/rt of ID).
//  HI/LO hazard: counter!=0 and ID is mfhi, mflo, mult or div.
//  stall_if = if_id_valid & ~flush & (load-use | HI/LO hazard). A stall cycle inserts a bubble in ex_q.
//  flush has priority over stall: stall_if=0, id_ex_valid<=0, ex_q<=bubble.
//   In-flight ex_q/mem_q entries and the muldiv counter are unaffected.
//  id_ex_valid <= issue (1-cycle latency, aligned with the ID/EX register).
//  fwd_a <= 01 if ex_q is a valid writer with dst==rs; else 10 if mem_q is a valid writer with dst==rs;
//   else 00. fwd_b uses rt with the same rule. EX/MEM has priority over MEM/WB.
//   Register 0 and unused operands always select 00. Value is 00 whenever issue=0.
//  Regfile is write-before-read, so a WB-stage producer needs no forward.
//  Muldiv counter: loads MULDIV_LAT on the edge that issues a mult/div; otherwise decrements while
//   nonzero. mflo/mfhi directly behind a mult therefore stalls exactly MULDIV_LAT cycles.
//  stall_cnt increments on each edge with stall_if=1 and saturates at all-ones.
//  if_id_valid=0: no stall, no issue, a bubble enters ex_q, and the counter still decrements.
// STRUCTURE
//  Package id_pkg: opcode/funct localparams, FWD_RF/FWD_EXMEM/FWD_MEMWB encodings,
//   and the typedef for the tracking entry.
//  Sub-module id_decode_lite (combinational): instr -> {rs, rt, rs_used, rt_used, dst, we, load,
//   muldiv, hilo_rd}.
//  Top level holds ex_q/mem_q, hazard/forward logic, the muldiv counter and stall_cnt.
// TESTING
//  1 lw $8,0($4) (0x8C880000), then add $9,$8,$6 (0x01064820): exactly 1 stall cycle, then issue
//    with fwd_a=10, fwd_b=00. stall_cnt=1.
//  2 add $8,$4,$6, then add $10,$8,$8: no stall; fwd_a=fwd_b=01. One nop between them gives 10/10.
//  3 mult $4,$6, then mflo $2 (MULDIV_LAT=4): 4 stall cycles, mflo issues when muldiv_busy falls.
//    A second mult behind the first also stalls 4.
//  4 Load-use stall in progress, flush=1 in the stall cycle: stall_if drops to 0 that cycle;
//    next cycle id_ex_valid=0 and fwd=00.
//  5 lw $0,0($4), then add $9,$0,$0: no stall, fwd=00/00.
//  6 rst_n low for 1 cycle while the muldiv counter=3 and stall_cnt=7: outputs go to reset values
//    asynchronously; a mflo after release issues with no stall.

Source files
------------

// File: rtl/id_pkg.sv
// Shared definitions for the ID-stage issue/hazard controller:
// MIPS opcode/funct codes, forwarding-select encodings and the
// decoded-instruction / in-flight-writer record types.
package id_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    // In-flight writer tracked in EX or MEM
    typedef struct packed {
        logic       valid;
        logic [4:0] dst;
        logic       we;
        logic       load;
    } track_t;

    // Decoded view of the instruction sitting in ID
    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       rs_used;
        logic       rt_used;
        logic [4:0] dst;
        logic       we;
        logic       load;
        logic       muldiv;
        logic       hilo_rd;
    } dec_t;

    // True when a tracked entry will write register r (we already excludes $0)
    function automatic logic writes_reg(input track_t e, input logic [4:0] r);
        return e.valid && e.we && (e.dst == r);
    endfunction

endpackage

// File: rtl/id_decode_lite.sv
// Minimal decoder: extracts register fields, operand usage, the
// destination register and the load / mult-div / HI-LO-read flags.
module id_decode_lite
    import id_pkg::*;
(
    input  logic [31:0] i_instr,
    output dec_t        o_dec
);

    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic [4:0] w_rd;
    logic       w_unused_shamt;

    assign w_op           = i_instr[31:26];
    assign w_funct        = i_instr[5:0];
    assign w_rd           = i_instr[15:11];
    assign w_unused_shamt = ^i_instr[10:6];

    // Opcode/funct decode; writes to $0 are folded into we=0
    always_comb begin
        o_dec         = '0;
        o_dec.rs      = i_instr[25:21];
        o_dec.rt      = i_instr[20:16];
        case (w_op)
            OP_RTYPE: begin
                case (w_funct)
                    FN_MULT, FN_DIV: begin
                        o_dec.rs_used = 1'b1;
                        o_dec.rt_used = 1'b1;
                        o_dec.muldiv  = 1'b1;
                    end
                    FN_MFHI, FN_MFLO: begin
                        o_dec.dst     = w_rd;
                        o_dec.hilo_rd = 1'b1;
                    end
                    default: begin
                        o_dec.dst     = w_rd;
                        o_dec.rs_used = 1'b1;
                        o_dec.rt_used = 1'b1;
                    end
                endcase
            end
            OP_LW: begin
                o_dec.dst     = o_dec.rt;
                o_dec.rs_used = 1'b1;
                o_dec.load    = 1'b1;
            end
            OP_SW, OP_BEQ: begin
                o_dec.rs_used = 1'b1;
                o_dec.rt_used = 1'b1;
            end
            OP_ADDI: begin
                o_dec.dst     = o_dec.rt;
                o_dec.rs_used = 1'b1;
            end
            OP_J: begin
                o_dec.dst     = '0;
            end
            default: begin
                o_dec.dst     = '0;
            end
        endcase
        o_dec.we = (o_dec.dst != 5'd0);
    end

endmodule

// File: rtl/id_hazard_scheduler.sv
// ID-stage issue/hazard controller: tracks writers in EX and MEM,
// detects load-use and HI/LO interlocks, drives the IF stall, the
// ID/EX valid bit and the EX forwarding selects, and times the
// multi-cycle mult/div unit.
module id_hazard_scheduler
    import id_pkg::*;
#(
    parameter int unsigned SIZE       = 32,
    parameter int unsigned MULDIV_LAT = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_id_valid,
    input  logic [SIZE-1:0]  if_id_instr,
    input  logic             flush,
    output logic             stall_if,
    output logic             id_ex_valid,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             muldiv_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned MD_W = $clog2(MULDIV_LAT + 1);

    dec_t            w_dec;
    track_t          r_ex_q;
    track_t          r_mem_q;
    track_t          w_ex_next;
    logic [MD_W-1:0] r_md_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic            r_id_ex_valid;
    logic [1:0]      r_fwd_a;
    logic [1:0]      r_fwd_b;
    logic            w_load_use;
    logic            w_hilo_haz;
    logic            w_stall;
    logic            w_issue;
    logic [1:0]      w_fwd_a;
    logic [1:0]      w_fwd_b;

    id_decode_lite u_decode (
        .i_instr (if_id_instr[31:0]),
        .o_dec   (w_dec)
    );

    // Hazard detection, issue decision and next EX tracking entry
    always_comb begin
        w_load_use = r_ex_q.valid && r_ex_q.load && r_ex_q.we &&
                     ((w_dec.rs_used && (r_ex_q.dst == w_dec.rs)) ||
                      (w_dec.rt_used && (r_ex_q.dst == w_dec.rt)));
        w_hilo_haz = (r_md_cnt != '0) && (w_dec.hilo_rd || w_dec.muldiv);
        w_stall    = if_id_valid && !flush && (w_load_use || w_hilo_haz);
        w_issue    = if_id_valid && !w_stall && !flush;
        w_ex_next  = '0;
        if (w_issue) begin
            w_ex_next.valid = 1'b1;
            w_ex_next.dst   = w_dec.dst;
            w_ex_next.we    = w_dec.we;
            w_ex_next.load  = w_dec.load;
        end
    end

    // Forward selects for the instruction about to enter EX; EX/MEM beats MEM/WB
    always_comb begin
        w_fwd_a = FWD_RF;
        w_fwd_b = FWD_RF;
        if (w_issue && w_dec.rs_used && (w_dec.rs != 5'd0)) begin
            if (writes_reg(r_ex_q, w_dec.rs))       w_fwd_a = FWD_EXMEM;
            else if (writes_reg(r_mem_q, w_dec.rs)) w_fwd_a = FWD_MEMWB;
        end
        if (w_issue && w_dec.rt_used && (w_dec.rt != 5'd0)) begin
            if (writes_reg(r_ex_q, w_dec.rt))       w_fwd_b = FWD_EXMEM;
            else if (writes_reg(r_mem_q, w_dec.rt)) w_fwd_b = FWD_MEMWB;
        end
    end

    // Pipeline tracking and registered EX-side outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_q        <= '0;
            r_mem_q       <= '0;
            r_id_ex_valid <= 1'b0;
            r_fwd_a       <= FWD_RF;
            r_fwd_b       <= FWD_RF;
        end else begin
            r_mem_q       <= r_ex_q;
            r_ex_q        <= w_ex_next;
            r_id_ex_valid <= w_issue;
            r_fwd_a       <= w_fwd_a;
            r_fwd_b       <= w_fwd_b;
        end
    end

    // Mult/div occupancy: reload on issue, else count down to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_md_cnt <= '0;
        end else if (w_issue && w_dec.muldiv) begin
            r_md_cnt <= MD_W'(MULDIV_LAT);
        end else if (r_md_cnt != '0) begin
            r_md_cnt <= r_md_cnt - MD_W'(1);
        end
    end

    // Saturating count of stalled cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_if    = w_stall;
    assign id_ex_valid = r_id_ex_valid;
    assign fwd_a       = r_fwd_a;
    assign fwd_b       = r_fwd_b;
    assign muldiv_busy = (r_md_cnt != '0);
    assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_id_hazard_scheduler.sv
// Self-checking bench for id_hazard_scheduler. Each cycle the expected
// registered EX-side outputs are queued when the ID inputs are driven and
// compared after the following clock edge.
module tb_id_hazard_scheduler;

    localparam int unsigned CNT_W = 16;

    localparam logic [31:0] I_LW_8_4   = 32'h8C880000; // lw   $8,0($4)
    localparam logic [31:0] I_ADD_9_86 = 32'h01064820; // add  $9,$8,$6
    localparam logic [31:0] I_ADD_8_46 = 32'h00864020; // add  $8,$4,$6
    localparam logic [31:0] I_ADD_A_88 = 32'h01085020; // add  $10,$8,$8
    localparam logic [31:0] I_NOP      = 32'h00000000;
    localparam logic [31:0] I_MULT_46  = 32'h00860018; // mult $4,$6
    localparam logic [31:0] I_MFLO_2   = 32'h00001012; // mflo $2
    localparam logic [31:0] I_LW_0_4   = 32'h8C800000; // lw   $0,0($4)
    localparam logic [31:0] I_ADD_9_00 = 32'h00004820; // add  $9,$0,$0

    logic             clk;
    logic             rst_n;
    logic             if_id_valid;
    logic [31:0]      if_id_instr;
    logic             flush;
    logic             stall_if;
    logic             id_ex_valid;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             muldiv_busy;
    logic [CNT_W-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic       v;
        logic [1:0] fa;
        logic [1:0] fb;
    } exp_t;

    exp_t sb[$];

    id_hazard_scheduler #(
        .SIZE       (32),
        .MULDIV_LAT (4),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .if_id_valid (if_id_valid),
        .if_id_instr (if_id_instr),
        .flush       (flush),
        .stall_if    (stall_if),
        .id_ex_valid (id_ex_valid),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .muldiv_busy (muldiv_busy),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Enters and leaves at 1ns after a rising edge
    task automatic do_reset();
        if_id_valid = 1'b0;
        if_id_instr = '0;
        flush       = 1'b0;
        rst_n       = 1'b0;
        @(posedge clk); #1;
        rst_n       = 1'b1;
    endtask

    // One ID cycle: drive, check combinational outputs mid-cycle,
    // then pop and check the registered outputs after the edge.
    task automatic cycle(input string name, input logic v, input logic [31:0] instr,
                         input logic fl, input logic e_stall, input logic e_busy,
                         input logic e_v, input logic [1:0] e_fa, input logic [1:0] e_fb);
        exp_t e;
        exp_t got;
        if_id_valid = v;
        if_id_instr = instr;
        flush       = fl;
        e.name = name; e.v = e_v; e.fa = e_fa; e.fb = e_fb;
        sb.push_back(e);
        @(negedge clk);
        checks++;
        if (stall_if !== e_stall) begin
            errors++;
            $display("FAIL %s stall_if: got %0b expected %0b", name, stall_if, e_stall);
        end
        checks++;
        if (muldiv_busy !== e_busy) begin
            errors++;
            $display("FAIL %s muldiv_busy: got %0b expected %0b", name, muldiv_busy, e_busy);
        end
        @(posedge clk); #1;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard: got empty queue expected one entry", name);
        end else begin
            got = sb.pop_front();
            if (id_ex_valid !== got.v || fwd_a !== got.fa || fwd_b !== got.fb) begin
                errors++;
                $display("FAIL %s ex-side: got v=%0b fa=%02b fb=%02b expected v=%0b fa=%02b fb=%02b",
                         got.name, id_ex_valid, fwd_a, fwd_b, got.v, got.fa, got.fb);
            end
        end
    endtask

    task automatic check_cnt(input string name, input logic [CNT_W-1:0] exp_cnt);
        checks++;
        if (stall_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL %s stall_cnt: got %0d expected %0d", name, stall_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset();
        if_id_valid = 1'b0;
        if_id_instr = '0;
        flush       = 1'b0;
        rst_n       = 1'b0;
        #2;
        checks++;
        if (id_ex_valid !== 1'b0 || fwd_a !== 2'b00 || fwd_b !== 2'b00 ||
            muldiv_busy !== 1'b0 || stall_cnt !== '0 || stall_if !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: got v=%0b fa=%02b fb=%02b busy=%0b cnt=%0d stall=%0b expected all zero",
                     id_ex_valid, fwd_a, fwd_b, muldiv_busy, stall_cnt, stall_if);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycle("reset_idle", 1'b0, I_NOP, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    endtask

    task automatic test_load_use();
        do_reset();
        cycle("lu_lw",     1'b1, I_LW_8_4,   1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
        cycle("lu_stall",  1'b1, I_ADD_9_86, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
        cycle("lu_issue",  1'b1, I_ADD_9_86, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00);
        check_cnt("lu_cnt", 16'd1);
    endtask

    task automatic test_forward();
        do_reset();
        cycle("fw_a1",  1'b1, I_ADD_8_46, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
        cycle("fw_b1",  1'b1, I_ADD_A_88, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b01);
        do_reset();
        cycle("fw_a2",  1'b1, I_ADD_8_46, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
        cycle("fw_nop", 1'b1, I_NOP,      1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
        cycle("fw_b2",  1'b1, I_ADD_A_88, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b10);
        check_cnt("fw_cnt", 16'd0);
    endtask

    task automatic test_muldiv();
        do_reset();
        cycle("md_mult", 1'b1, I_MULT_46, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
        for (int i = 0; i < 4; i++)
            cycle("md_mflo_stall", 1'b1, I_MFLO_2, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
        cycle("md_mflo_issue", 1'b1, I_MFLO_2, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
        check_cnt("md_cnt4", 16'd4);
        cycle("md_mult1", 1'b1, I_MULT_46, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
        for (int i = 0; i < 4; i++)
            cycle("md_mult2_stall", 1'b1, I_MULT_46, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
        cycle("md_mult2_issue", 1'b1, I_MULT_46, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
        for (int i = 0; i < 4; i++)
            cycle("md_drain", 1'b0, I_NOP, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
        cycle("md_idle", 1'b0, I_NOP, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        check_cnt("md_cnt8", 16'd8);
    endtask

    task automatic test_flush();
        do_reset();
        cycle("fl_lw",    1'b1, I_LW_8_4,   1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
        cycle("fl_flush", 1'b1, I_ADD_9_86, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        cycle("fl_after", 1'b1, I_ADD_9_86, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00);
        check_cnt("fl_cnt", 16'd0);
    endtask

    task automatic test_reg_zero();
        do_reset();
        cycle("z_lw",  1'b1, I_LW_0_4,   1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
        cycle("z_add", 1'b1, I_ADD_9_00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
        check_cnt("z_cnt", 16'd0);
    endtask

    task automatic test_async_reset();
        do_reset();
        cycle("ar_mult", 1'b1, I_MULT_46, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
        for (int i = 0; i < 4; i++)
            cycle("ar_mflo_stall", 1'b1, I_MFLO_2, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
        cycle("ar_mflo", 1'b1, I_MFLO_2, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
        for (int k = 0; k < 2; k++) begin
            cycle("ar_lw",     1'b1, I_LW_8_4,   1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
            cycle("ar_stall",  1'b1, I_ADD_9_86, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
            cycle("ar_add",    1'b1, I_ADD_9_86, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00);
        end
        cycle("ar_mult2", 1'b1, I_MULT_46, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
        cycle("ar_mflo_s", 1'b1, I_MFLO_2, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
        check_cnt("ar_cnt7", 16'd7);
        checks++;
        if (muldiv_busy !== 1'b1) begin
            errors++;
            $display("FAIL ar_busy_before: got %0b expected 1", muldiv_busy);
        end
        if_id_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (id_ex_valid !== 1'b0 || fwd_a !== 2'b00 || fwd_b !== 2'b00 ||
            muldiv_busy !== 1'b0 || stall_cnt !== '0) begin
            errors++;
            $display("FAIL ar_async: got v=%0b fa=%02b fb=%02b busy=%0b cnt=%0d expected all zero",
                     id_ex_valid, fwd_a, fwd_b, muldiv_busy, stall_cnt);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycle("ar_mflo_after", 1'b1, I_MFLO_2, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
        check_cnt("ar_cnt0", 16'd0);
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_forward();
        test_muldiv();
        test_flush();
        test_reg_zero();
        test_async_reset();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
